// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester handshake, the FIFO write port and the arbiter
// status outputs of fifo_wr_arbiter into one interface.
//   master : the arbiter (consumes req_valid/req_data and the FIFO flags,
//            drives req_ready, fifo_winc, fifo_wdata, grant_id, busy, wr_cnt)
//   slave  : the environment (requesters + FIFO), opposite directions
// Parameters: NREQ requesters, DATA_W word width, CNT_W counter width.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
   localparam int ID_W = $clog2(NREQ);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   fifo_wfull;
   logic                   fifo_wfull_almost;
   logic                   fifo_winc;
   logic [DATA_W-1:0]      fifo_wdata;
   logic [ID_W-1:0]        grant_id;
   logic                   busy;
   logic [CNT_W-1:0]       wr_cnt;

   modport master (
      input  req_valid, req_data, fifo_wfull, fifo_wfull_almost,
      output req_ready, fifo_winc, fifo_wdata, grant_id, busy, wr_cnt
   );

   modport slave (
      output req_valid, req_data, fifo_wfull, fifo_wfull_almost,
      input  req_ready, fifo_winc, fifo_wdata, grant_id, busy, wr_cnt
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin burst arbiter sharing the single write port of the async FIFO
// among NREQ requesters in the write-clock domain. One requester at a time
// holds a grant for up to BURST words; FIFO full stalls the current beat,
// almost-full ends the burst after the current beat and blocks new grants.
// Ports:
//   wclk  - write-domain clock
//   wrst  - synchronous active-high reset
//   bus   - fifo_wr_arbiter_if.master: req_valid/req_data/req_ready,
//           fifo_wfull/fifo_wfull_almost/fifo_winc/fifo_wdata,
//           grant_id, busy, wr_cnt (saturating written-word count)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8,
   parameter int BURST  = 4,
   parameter int CNT_W  = 16
) (
   input logic               wclk,
   input logic               wrst,
   fifo_wr_arbiter_if.master bus
);
   localparam int ID_W   = $clog2(NREQ);
   localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
   localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NREQ - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t            state_r;
   logic [ID_W-1:0]   grant_id_r;
   logic [ID_W-1:0]   rr_ptr_r;
   logic [BEAT_W-1:0] beat_cnt_r;
   logic [CNT_W-1:0]  wr_cnt_r;
   logic              busy_r;

   logic [ID_W-1:0]   winner_s;
   logic [ID_W-1:0]   next_ptr_s;
   logic [NREQ-1:0]   ready_s;
   logic              any_req_s;
   logic              sel_valid_s;
   logic              xfer_s;
   logic              burst_end_s;

   assign any_req_s   = |bus.req_valid;
   assign sel_valid_s = bus.req_valid[grant_id_r];
   // wrst masks the strobe combinationally so a reset mid-burst writes nothing
   assign xfer_s      = (state_r == GRANT) && sel_valid_s && !bus.fifo_wfull && !wrst;
   assign burst_end_s = (beat_cnt_r == LAST_BEAT) || bus.fifo_wfull_almost;
   assign next_ptr_s  = (grant_id_r == LAST_ID) ? {ID_W{1'b0}} : grant_id_r + ID_W'(1);

   // Round-robin search: scan offsets high to low so the smallest offset
   // from rr_ptr that has a valid request is the one left in winner_s.
   always_comb begin : rr_search
      logic [ID_W-1:0] idx;
      winner_s = {ID_W{1'b0}};
      idx      = {ID_W{1'b0}};
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx      = ID_W'((int'(rr_ptr_r) + i) % NREQ);
         winner_s = bus.req_valid[idx] ? idx : winner_s;
      end
   end

   // Only the grantee sees ready, and only while the FIFO can take a word.
   always_comb begin
      ready_s = {NREQ{1'b0}};
      if ((state_r == GRANT) && !wrst) begin
         ready_s[grant_id_r] = !bus.fifo_wfull;
      end else begin
         ready_s = {NREQ{1'b0}};
      end
   end

   // Arbitration FSM: grant, beat counting, burst termination, pointer update.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_r    <= IDLE;
         grant_id_r <= {ID_W{1'b0}};
         rr_ptr_r   <= {ID_W{1'b0}};
         beat_cnt_r <= {BEAT_W{1'b0}};
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s && !bus.fifo_wfull && !bus.fifo_wfull_almost) begin
                  state_r    <= GRANT;
                  grant_id_r <= winner_s;
                  beat_cnt_r <= {BEAT_W{1'b0}};
                  busy_r     <= 1'b1;
               end
            end
            GRANT: begin
               // Dropping valid forfeits the grant; a full FIFO just stalls.
               if (!sel_valid_s || (xfer_s && burst_end_s)) begin
                  state_r  <= IDLE;
                  busy_r   <= 1'b0;
                  rr_ptr_r <= next_ptr_s;
               end else if (xfer_s) begin
                  beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of words written into the FIFO.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wr_cnt_r <= {CNT_W{1'b0}};
      end else if (xfer_s && (wr_cnt_r != {CNT_W{1'b1}})) begin
         wr_cnt_r <= wr_cnt_r + CNT_W'(1);
      end
   end

   assign bus.req_ready  = ready_s;
   assign bus.fifo_winc  = xfer_s;
   assign bus.fifo_wdata = bus.req_data[int'(grant_id_r) * DATA_W +: DATA_W];
   assign bus.grant_id   = grant_id_r;
   assign bus.busy       = busy_r;
   assign bus.wr_cnt     = wr_cnt_r;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Two arbiter instances share the FIFO flags and reset: dut_a (BURST=4,
// CNT_W=16) and dut_b (BURST=2, CNT_W=4). Each has its own requester word
// sources. A behavioural model (owner / words-in-burst / next pointer /
// count) predicts every output each cycle; directed scenarios add literal
// expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
   logic wclk;
   logic wrst;

   fifo_wr_arbiter_if #(.NREQ(4), .DATA_W(8), .CNT_W(16)) if_a ();
   fifo_wr_arbiter_if #(.NREQ(4), .DATA_W(8), .CNT_W(4))  if_b ();

   fifo_wr_arbiter #(.NREQ(4), .DATA_W(8), .BURST(4), .CNT_W(16)) dut_a (
      .wclk(wclk), .wrst(wrst), .bus(if_a.master));
   fifo_wr_arbiter #(.NREQ(4), .DATA_W(8), .BURST(2), .CNT_W(4)) dut_b (
      .wclk(wclk), .wrst(wrst), .bus(if_b.master));

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int n_checks = 0;
   int n_fail   = 0;

   // shared controls, applied at the next negedge by step()
   logic c_wrst   = 1'b1;
   logic c_wfull  = 1'b0;
   logic c_almost = 1'b0;

   // requester sources per DUT
   int s_left [2][4];
   int s_seq  [2][4];
   int s_base [2][4];
   bit s_drop [2][4];

   // behavioural model per DUT
   int burst_k [2] = '{4, 2};
   int cmax_k  [2] = '{65535, 15};
   int m_owner [2];
   int m_last  [2];
   int m_next  [2];
   int m_words [2];
   int m_cnt   [2];
   bit m_known = 1'b0;

   // observed outputs of the latest step
   int o_ready [2];
   int o_winc  [2];
   int o_wdata [2];
   int o_grant [2];
   int o_busy  [2];
   int o_cnt   [2];

   function automatic void check(string name, int k, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s (dut%0d) at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
      end
   endfunction

   task automatic model_cycle(input int k, input logic [3:0] v);
      int own;
      int e_ready;
      int e_winc;
      own     = m_owner[k];
      e_ready = 0;
      e_winc  = 0;
      if (!c_wrst && own >= 0) begin
         if (!c_wfull) e_ready = 1 << own;
         e_winc = (v[own] && !c_wfull) ? 1 : 0;
      end
      if (m_known || c_wrst) begin
         check("req_ready", k, o_ready[k], e_ready);
         check("fifo_winc", k, o_winc[k], e_winc);
      end
      if (m_known) begin
         check("busy", k, o_busy[k], (own >= 0) ? 1 : 0);
         check("grant_id", k, o_grant[k], m_last[k]);
         check("wr_cnt", k, o_cnt[k], m_cnt[k]);
         if (e_winc == 1) check("fifo_wdata", k, o_wdata[k], (s_base[k][own] + s_seq[k][own]) & 255);
      end
      if (c_wrst) begin
         m_owner[k] = -1; m_last[k] = 0; m_next[k] = 0; m_words[k] = 0; m_cnt[k] = 0;
      end else if (m_known) begin
         if (own < 0) begin
            if (v != 4'b0000 && !c_wfull && !c_almost) begin
               for (int off = 0; off < 4; off++)
                  if (m_owner[k] < 0 && v[(m_next[k] + off) % 4]) m_owner[k] = (m_next[k] + off) % 4;
               m_last[k]  = m_owner[k];
               m_words[k] = 0;
            end
         end else if (!v[own]) begin
            m_next[k]  = (own + 1) % 4;
            m_owner[k] = -1;
         end else if (!c_wfull) begin
            m_words[k]++;
            if (m_cnt[k] < cmax_k[k]) m_cnt[k]++;
            s_seq[k][own]++;
            s_left[k][own]--;
            if (m_words[k] == burst_k[k] || c_almost) begin
               m_next[k]  = (own + 1) % 4;
               m_owner[k] = -1;
            end
         end
      end
   endtask

   // one clock cycle: drive at negedge, sample 1 ns later, compare, advance model
   task automatic step();
      logic [3:0]  v [2];
      logic [31:0] d [2];
      @(negedge wclk);
      for (int k = 0; k < 2; k++) begin
         v[k] = 4'b0000;
         d[k] = 32'h0;
         for (int i = 0; i < 4; i++) begin
            v[k][i]        = (s_left[k][i] > 0) && !s_drop[k][i];
            d[k][i*8 +: 8] = 8'(s_base[k][i] + s_seq[k][i]);
         end
      end
      wrst = c_wrst;
      if_a.req_valid = v[0]; if_a.req_data = d[0];
      if_a.fifo_wfull = c_wfull; if_a.fifo_wfull_almost = c_almost;
      if_b.req_valid = v[1]; if_b.req_data = d[1];
      if_b.fifo_wfull = c_wfull; if_b.fifo_wfull_almost = c_almost;
      #1;
      o_ready[0] = int'(if_a.req_ready); o_winc[0] = int'(if_a.fifo_winc);
      o_wdata[0] = int'(if_a.fifo_wdata); o_grant[0] = int'(if_a.grant_id);
      o_busy[0]  = int'(if_a.busy);      o_cnt[0]   = int'(if_a.wr_cnt);
      o_ready[1] = int'(if_b.req_ready); o_winc[1] = int'(if_b.fifo_winc);
      o_wdata[1] = int'(if_b.fifo_wdata); o_grant[1] = int'(if_b.grant_id);
      o_busy[1]  = int'(if_b.busy);      o_cnt[1]   = int'(if_b.wr_cnt);
      for (int k = 0; k < 2; k++) model_cycle(k, v[k]);
      if (c_wrst) m_known = 1'b1;
   endtask

   task automatic reset_all();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 4; i++) begin
            s_left[k][i] = 0; s_seq[k][i] = 0; s_base[k][i] = 64 * i; s_drop[k][i] = 1'b0;
         end
      c_wfull = 1'b0; c_almost = 1'b0;
      c_wrst = 1'b1;
      step();
      step();
      c_wrst = 1'b0;
   endtask

   initial begin
      int   nwd;
      int   wd [8];
      logic [7:0]  pat;
      logic [14:0] bb;
      int   order [5];
      int   bw [5];
      int   nb;
      int   total;
      int   exp_order [5] = '{0, 1, 2, 3, 0};
      bit   done;

      wrst = 1'b1;
      if_a.req_valid = 4'b0000; if_a.req_data = 32'h0; if_a.fifo_wfull = 1'b0; if_a.fifo_wfull_almost = 1'b0;
      if_b.req_valid = 4'b0000; if_b.req_data = 32'h0; if_b.fifo_wfull = 1'b0; if_b.fifo_wfull_almost = 1'b0;

      // reset state
      reset_all();
      step();
      check("reset busy", 0, o_busy[0], 0);
      check("reset wr_cnt", 0, o_cnt[0], 0);
      check("reset grant_id", 1, o_grant[1], 0);

      // 1: single requester, 6 words 0x10..0x15
      reset_all();
      s_base[0][0] = 8'h10; s_left[0][0] = 6;
      nwd = 0; pat = 8'h00;
      for (int c = 0; c < 8; c++) begin
         step();
         pat[c] = o_winc[0][0];
         if (o_winc[0] == 1 && nwd < 8) begin wd[nwd] = o_wdata[0]; nwd++; end
      end
      check("t1 winc pattern", 0, int'(pat), int'(8'b1101_1110));
      check("t1 word count", 0, nwd, 6);
      for (int i = 0; i < 6; i++) check("t1 wdata", 0, wd[i], 8'h10 + i);
      step();
      check("t1 wr_cnt", 0, o_cnt[0], 6);
      check("t1 grant_id", 0, o_grant[0], 0);

      // 2: all requesters, BURST=2 on dut_b
      reset_all();
      for (int i = 0; i < 4; i++) s_left[1][i] = 100;
      bb = 15'h0; nb = 0;
      for (int j = 0; j < 5; j++) begin order[j] = -1; bw[j] = 0; end
      for (int c = 0; c < 15; c++) begin
         step();
         bb[c] = o_busy[1][0];
         if (o_busy[1] == 1 && (c == 0 || !bb[c-1])) begin
            if (nb < 5) order[nb] = o_grant[1];
            nb++;
         end
         if (o_winc[1] == 1 && nb >= 1 && nb <= 5) bw[nb-1]++;
      end
      check("t2 busy pattern", 1, int'(bb), int'(15'b110_110_110_110_110));
      for (int j = 0; j < 5; j++) begin
         check("t2 grant order", 1, order[j], exp_order[j]);
         check("t2 burst words", 1, bw[j], 2);
      end
      step();
      check("t2 wr_cnt", 1, o_cnt[1], 10);

      // 3: mid-burst full on requester 2
      reset_all();
      s_left[0][2] = 4;
      step();
      step();
      check("t3 first word", 0, o_winc[0], 1);
      check("t3 grant_id", 0, o_grant[0], 2);
      c_wfull = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("t3 stall winc", 0, o_winc[0], 0);
         check("t3 stall ready", 0, (o_ready[0] >> 2) & 1, 0);
         check("t3 stall busy", 0, o_busy[0], 1);
      end
      c_wfull = 1'b0;
      total = 1; done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         step();
         if (o_winc[0] == 1) total++;
         if (o_busy[0] == 0) done = 1'b1;
      end
      check("t3 burst end seen", 0, int'(done), 1);
      check("t3 total words", 0, total, 4);

      // 4: almost-full during requester 1's second beat
      reset_all();
      s_left[0][1] = 10; s_left[0][3] = 10;
      step();
      step();
      total = o_winc[0];
      c_almost = 1'b1;
      step();
      check("t4 beat under almost", 0, o_winc[0], 1);
      total += o_winc[0];
      check("t4 burst words", 0, total, 2);
      for (int c = 0; c < 4; c++) begin
         step();
         check("t4 held idle busy", 0, o_busy[0], 0);
         check("t4 held idle winc", 0, o_winc[0], 0);
      end
      c_almost = 1'b0;
      step();
      step();
      check("t4 next busy", 0, o_busy[0], 1);
      check("t4 next grant rr_ptr=2", 0, o_grant[0], 3);

      // 5: requester 3 drops valid after one word
      reset_all();
      s_left[0][3] = 5;
      step();
      step();
      check("t5 first word", 0, o_winc[0], 1);
      s_drop[0][3] = 1'b1; s_left[0][0] = 3;
      step();
      check("t5 drop winc", 0, o_winc[0], 0);
      step();
      check("t5 idle busy", 0, o_busy[0], 0);
      step();
      check("t5 regrant busy", 0, o_busy[0], 1);
      check("t5 regrant id", 0, o_grant[0], 0);

      // 6: reset mid-burst
      reset_all();
      s_left[0][2] = 10;
      step();
      step();
      check("t6 pre-reset winc", 0, o_winc[0], 1);
      c_wrst = 1'b1;
      step();
      check("t6 reset winc", 0, o_winc[0], 0);
      check("t6 reset ready", 0, o_ready[0], 0);
      c_wrst = 1'b0;
      step();
      check("t6 post busy", 0, o_busy[0], 0);
      check("t6 post wr_cnt", 0, o_cnt[0], 0);
      check("t6 post grant_id", 0, o_grant[0], 0);

      // saturation on the 4-bit counter of dut_b
      reset_all();
      s_left[1][0] = 20;
      total = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         total += o_winc[1];
      end
      check("sat words written", 1, total, 20);
      check("sat wr_cnt", 1, o_cnt[1], 15);

      // randomized traffic on both instances
      reset_all();
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 2; k++)
            if ($urandom_range(0, 3) == 0) s_left[k][$urandom_range(0, 3)] += $urandom_range(1, 6);
         c_wfull  = ($urandom_range(0, 4) == 0);
         c_almost = ($urandom_range(0, 5) == 0);
         c_wrst   = ($urandom_range(0, 199) == 0);
         step();
      end
      c_wrst = 1'b0; c_wfull = 1'b0; c_almost = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
